cpu_debug_scanner: RTL
======================

CPU_DEBUG_SCANNER -- requirements
Module: cpu_debug_scanner

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset (named reset; active-high, synchronous).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 start  in  1  single-cycle request to begin a scan; honoured only in IDLE.
REQ-005 mem_base  in  32  byte address of first memory word; latched on accepted start.
REQ-006 mem_words  in  5  number of memory words to read (0..16); latched on accepted start.
REQ-007 rf_addr  out  5  register-file debug read address driven to CPU.
REQ-008 mem_addr  out  32  data-memory debug read address driven to CPU.
REQ-009 rf_data  in  32  CPU register-file debug read data.
REQ-010 mem_data  in  32  CPU data-memory debug read data.
REQ-011 out_valid  out  1  out_data/out_tag/out_last hold a valid item.
REQ-012 out_ready  in  1  consumer accepts the item when high with out_valid.
REQ-013 out_data  out  32  captured word.
REQ-014 out_tag  out  6  {is_mem, index[4:0]}: is_mem=0 means register index, 1 means memory word index.
REQ-015 out_last  out  1  item is the final one of the scan.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the last item is accepted.

Function
REQ-018 States SHALL be IDLE, REQ, WAIT, SEND, DONE.
REQ-019 IDLE: start=1 -> latch mem_base with bits [1:0] forced to 00, latch count = min(mem_words,16), index=0, phase=RF -> REQ.
REQ-020 REQ: register rf_addr=index (RF phase) or mem_addr=base+4*index (MEM phase) -> WAIT.
REQ-021 WAIT: one cycle for CPU read latency; on exit capture rf_data or mem_data into out_data, set out_tag and out_last, out_valid=1 -> SEND.
REQ-022 SEND: out_valid held high, out_data/out_tag/out_last held stable until out_ready=1; out_ready=0 stalls indefinitely.
REQ-023 SEND with out_ready=1: out_valid=0; if item was last -> DONE; else advance index -> REQ.
REQ-024 Advance: RF phase index 31 -> MEM phase index 0 if count>0; otherwise index+1.
REQ-025 Scan order: registers 0..31 (r0 included), then memory words 0..count-1; total 32+count items.
REQ-026 out_last=1 only on register 31 when count=0, otherwise only on memory word count-1.
REQ-027 Memory address arithmetic SHALL be modulo 2^32 (base 0xFFFFFFFC, index 1 -> 0x00000000).
REQ-028 mem_words > 16 SHALL clamp to 16; mem_words = 0 SHALL scan registers only.
REQ-029 DONE: done=1 for exactly one cycle -> IDLE.
REQ-030 start while busy SHALL be ignored and SHALL NOT alter the latched base or count.
REQ-031 rf_addr/mem_addr SHALL hold their last driven value outside REQ.
REQ-032 Per item, REQ-to-out_valid latency SHALL be 2 cycles; with out_ready tied high, a full scan SHALL take 3*(32+count)+1 cycles from start to done.

Reset
REQ-033 reset=1 SHALL force IDLE, and set rf_addr=0, mem_addr=0, out_data=0, out_tag=0, out_valid=0, out_last=0, busy=0, done=0, index=0.
REQ-034 reset SHALL take priority over start, out_ready and every state transition, including mid-scan and during SEND; the pending item is dropped.

Verification
REQ-035 A bench SHALL cover: out_ready=1, mem_words=0, rf[i]=i*0x11 -> 32 items with tags 0x00..0x1F and data i*0x11, out_last only on tag 0x1F, done 97 cycles after start.
REQ-036 A bench SHALL cover: mem_base=0x00000100, mem_words=3 -> mem_addr 0x100, 0x104, 0x108; tags 0x20..0x22; out_last on 0x22.
REQ-037 A bench SHALL cover: out_ready held low for 10 cycles at item 5 -> out_valid stays high and out_data/out_tag are unchanged, no item is lost or duplicated, and the scan then continues.
REQ-038 A bench SHALL cover: mem_base=0xFFFFFFFE, mem_words=20 -> base treated as 0xFFFFFFFC, 16 memory words, second mem_addr=0x00000000.
REQ-039 A bench SHALL cover: reset asserted in SEND of item 10 -> next cycle all outputs are at their reset values; a following start rescans from tag 0x00.
REQ-040 A bench SHALL cover: start pulsed again mid-scan with a different mem_base -> ignored, and the original addresses are used.

Source files
------------

// File: rtl/cpu_debug_scanner.sv
// ============================================================================
// Module   : cpu_debug_scanner
// Brief    : Walks the CPU register file then a window of data memory through
//            the debug read ports, emitting each word on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_debug_scanner (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mem_base,
    input  logic [4:0]  mem_words,
    output logic [4:0]  rf_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] rf_data,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_tag,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] MAX_WORDS = 5'd16;
    localparam logic [4:0] LAST_REG  = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] base_q,     base_d;
    logic [4:0]  count_q,    count_d;
    logic [4:0]  index_q,    index_d;
    logic        is_mem_q,   is_mem_d;
    logic [4:0]  rf_addr_q,  rf_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic [5:0]  out_tag_q,  out_tag_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        done_q,     done_d;
    logic        w_is_last;

    // Last item: register 31 when no memory words are requested, otherwise
    // the final memory word of the window.
    always_comb begin
        if (is_mem_q) begin
            w_is_last = (index_q == (count_q - 5'd1));
        end else begin
            w_is_last = (index_q == LAST_REG) && (count_q == 5'd0);
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        index_d     = index_q;
        is_mem_d    = is_mem_q;
        rf_addr_d   = rf_addr_q;
        mem_addr_d  = mem_addr_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = {mem_base[31:2], 2'b00};
                    count_d  = (mem_words > MAX_WORDS) ? MAX_WORDS : mem_words;
                    index_d  = 5'd0;
                    is_mem_d = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (is_mem_q) begin
                    mem_addr_d = base_q + {25'd0, index_q, 2'b00};
                end else begin
                    rf_addr_d = index_q;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                out_data_d  = is_mem_q ? mem_data : rf_data;
                out_tag_d   = {is_mem_q, index_q};
                out_last_d  = w_is_last;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Not last after register 31 implies count > 0.
                        if (!is_mem_q && (index_q == LAST_REG)) begin
                            is_mem_d = 1'b1;
                            index_d  = 5'd0;
                        end else begin
                            index_d = index_q + 5'd1;
                        end
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= 32'd0;
            count_q     <= 5'd0;
            index_q     <= 5'd0;
            is_mem_q    <= 1'b0;
            rf_addr_q   <= 5'd0;
            mem_addr_q  <= 32'd0;
            out_data_q  <= 32'd0;
            out_tag_q   <= 6'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            index_q     <= index_d;
            is_mem_q    <= is_mem_d;
            rf_addr_q   <= rf_addr_d;
            mem_addr_q  <= mem_addr_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign rf_addr   = rf_addr_q;
    assign mem_addr  = mem_addr_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

`default_nettype wire
